// File: rtl/sa_pkg.sv
// Shared types and default sizing for the systolic-array activation feeder.
package sa_pkg;

  localparam int SA_N      = 4;
  localparam int SA_DATA_W = 8;
  localparam int SA_K_W    = 16;

  typedef logic [SA_DATA_W-1:0] act_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2
  } skew_state_t;

endpackage

// File: rtl/skew_delay_line.sv
// DEPTH-stage shift register of {valid,data}; stage DEPTH-1 drives the outputs.
module skew_delay_line #(
  parameter int DEPTH = 1,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic [W:0] stage_q [DEPTH];
  logic [W:0] stage_d [DEPTH];

  // Shift one stage per cycle; stage 0 takes the new lane value.
  always_comb begin
    stage_d[0] = {in_valid, in_data};
    for (int s = 1; s < DEPTH; s++) begin
      stage_d[s] = stage_q[s-1];
    end
  end

  // Stage registers, cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < DEPTH; s++) begin
        stage_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < DEPTH; s++) begin
        stage_q[s] <= stage_d[s];
      end
    end
  end

  assign out_valid = stage_q[DEPTH-1][W];
  assign out_data  = stage_q[DEPTH-1][W-1:0];

endmodule

// File: rtl/sa_input_skewer.sv
// Diagonal-skew activation feeder: row i sees lane i delayed by i+1 cycles,
// one tile of tile_len columns per start, then an N-cycle flush and a done pulse.
module sa_input_skewer
  import sa_pkg::*;
#(
  parameter int N      = SA_N,
  parameter int DATA_W = SA_DATA_W,
  parameter int K_W    = SA_K_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [K_W-1:0]      tile_len,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N*DATA_W-1:0] in_vec,
  output logic [N*DATA_W-1:0] row_data,
  output logic [N-1:0]        row_valid,
  output logic                busy,
  output logic                done
);

  localparam int FC_W = (N > 1) ? $clog2(N) : 1;

  skew_state_t     state_q, state_d;
  logic [K_W-1:0]  col_cnt_q, col_cnt_d;
  logic [K_W-1:0]  tile_len_q, tile_len_d;
  logic [FC_W-1:0] flush_cnt_q, flush_cnt_d;
  logic            done_q, done_d;
  logic            accept_s;

  assign in_ready = (state_q == LOAD);
  assign accept_s = in_valid && in_ready;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;

  // Tile sequencing: next state, counters and the done pulse.
  always_comb begin
    state_d     = state_q;
    col_cnt_d   = col_cnt_q;
    tile_len_d  = tile_len_q;
    flush_cnt_d = flush_cnt_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (tile_len != '0) begin
            state_d    = LOAD;
            tile_len_d = tile_len;
            col_cnt_d  = '0;
          end else begin
            done_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (accept_s) begin
          col_cnt_d = col_cnt_q + K_W'(1);
          if (col_cnt_q == tile_len_q - K_W'(1)) begin
            state_d     = FLUSH;
            flush_cnt_d = '0;
          end else begin
            state_d = LOAD;
          end
        end else begin
          state_d = LOAD;
        end
      end
      FLUSH: begin
        // N cycles lets the last column reach the deepest row.
        if (flush_cnt_q == FC_W'(N - 1)) begin
          state_d     = IDLE;
          flush_cnt_d = '0;
          done_d      = 1'b1;
        end else begin
          flush_cnt_d = flush_cnt_q + FC_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      col_cnt_q   <= '0;
      tile_len_q  <= '0;
      flush_cnt_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_cnt_q   <= col_cnt_d;
      tile_len_q  <= tile_len_d;
      flush_cnt_q <= flush_cnt_d;
      done_q      <= done_d;
    end
  end

  // Bubbles enter as zero data with valid low so they skew like real columns.
  for (genvar i = 0; i < N; i++) begin : g_row
    skew_delay_line #(
      .DEPTH (i + 1),
      .W     (DATA_W)
    ) u_delay (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (accept_s),
      .in_data   (accept_s ? in_vec[i*DATA_W +: DATA_W] : {DATA_W{1'b0}}),
      .out_valid (row_valid[i]),
      .out_data  (row_data[i*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_sa_input_skewer.sv
// Self-checking bench: directed tile plus randomized traffic against a
// cycle-indexed history model of accepted columns.
module tb_sa_input_skewer;
  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int KW   = 16;
  localparam int IW   = N * DW;
  localparam int MAXC = 8192;

  logic          clk = 1'b0;
  logic          rst, start, in_valid, in_ready, busy, done;
  logic [KW-1:0] tile_len;
  logic [IW-1:0] in_vec, row_data;
  logic [N-1:0]  row_valid;

  sa_input_skewer #(.N(N), .DATA_W(DW), .K_W(KW)) dut (
    .clk(clk), .rst(rst), .start(start), .tile_len(tile_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .row_data(row_data), .row_valid(row_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // Model: what was accepted in each cycle, plus tile bookkeeping in cycle numbers.
  bit            acc_v [MAXC];
  logic [IW-1:0] acc_d [MAXC];
  int remaining = 0;
  int idle_cyc  = 0;
  int done_cyc  = -1;
  int last_rst  = -1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [IW-1:0] exp_d;
    logic [N-1:0]  exp_v;
    if (cyc > 0) begin
      exp_d = '0;
      exp_v = '0;
      for (int i = 0; i < N; i++) begin
        int k;
        k = cyc - 1 - i;
        if (k >= 0 && k > last_rst && acc_v[k]) begin
          exp_v[i] = 1'b1;
          exp_d[i*DW +: DW] = acc_d[k][i*DW +: DW];
        end
      end
      chk("row_data", 64'(row_data), 64'(exp_d));
      chk("row_valid", 64'(row_valid), 64'(exp_v));
      chk("in_ready", 64'(in_ready), 64'(remaining > 0));
      chk("busy", 64'(busy), 64'(remaining > 0 || cyc < idle_cyc));
      chk("done", 64'(done), 64'(cyc == done_cyc));
    end
    acc_v[cyc] = 1'b0;
    if (rst) begin
      remaining = 0;
      idle_cyc  = 0;
      done_cyc  = -1;
      last_rst  = cyc;
    end else if (remaining > 0) begin
      if (in_valid) begin
        acc_v[cyc] = 1'b1;
        acc_d[cyc] = in_vec;
        remaining--;
        if (remaining == 0) begin
          idle_cyc = cyc + N + 1;
          done_cyc = cyc + N + 1;
        end
      end
    end else if (cyc >= idle_cyc && start) begin
      if (tile_len == '0) done_cyc = cyc + 1;
      else remaining = int'(tile_len);
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; tile_len = '0; in_valid = 1'b0; in_vec = '0;
    tick();
    tick();
    rst = 1'b0;
    start = 1'b1; tile_len = 16'd3;
    at_neg();
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_rows", 64'({row_valid, row_data}), 64'd0);
    tick();                                   // cycle T: first accept
    start = 1'b0; in_valid = 1'b1; in_vec = 32'h31211101;
    tick();
    start = 1'b1; tile_len = 16'd7;           // ignored mid-tile
    in_vec = 32'h32221202;
    tick();
    start = 1'b0; in_vec = 32'h33231303;
    tick();                                   // T+3
    in_valid = 1'b0; in_vec = '0;
    at_neg();
    chk("t1_row_data_T3", 64'(row_data), 64'h00211203);
    chk("t1_in_ready_T3", 64'(in_ready), 64'd0);
    tick();                                   // T+4
    start = 1'b1; tile_len = 16'd2;           // ignored in flush
    at_neg();
    chk("t1_row_data_T4", 64'(row_data), 64'h31221300);
    chk("t1_row_valid_T4", 64'(row_valid), 64'hE);
    tick();
    start = 1'b0;
    tick();                                   // T+6
    at_neg();
    chk("t1_row_data_T6", 64'(row_data), 64'h33000000);
    chk("t1_done_T6", 64'(done), 64'd0);
    tick();                                   // T+7: done, zero-length start
    start = 1'b1; tile_len = 16'd0;
    at_neg();
    chk("t1_done_T7", 64'(done), 64'd1);
    chk("t1_busy_T7", 64'(busy), 64'd0);
    tick();
    start = 1'b0;
    at_neg();
    chk("t3_done", 64'(done), 64'd1);
    chk("t3_busy", 64'(busy), 64'd0);
    chk("t3_row_valid", 64'(row_valid), 64'd0);

    for (int n = 0; n < 3000; n++) begin
      tick();
      rst      = ($urandom % 150) == 0;
      start    = ($urandom % 5) == 0;
      tile_len = KW'($urandom % 6);
      in_valid = ($urandom % 3) != 0;
      in_vec   = IW'($urandom);
    end
    tick();
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    for (int n = 0; n < 20; n++) tick();
    at_neg();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
